// File: rtl/bus_responder_pkg.sv
// Shared definitions for the bus responder: address map, STATUS layout, bus request.
package bus_responder_pkg;

  localparam int BUS_DW = 32;

  localparam logic [7:0] ADDR_CYCLES    = 8'h40;
  localparam logic [7:0] ADDR_FIFO_PUSH = 8'h41;
  localparam logic [7:0] ADDR_STATUS    = 8'h42;

  // STATUS bit positions
  localparam int ST_OVERFLOW = 31;
  localparam int ST_COLLIDE  = 30;
  localparam int ST_FULL     = 7;
  localparam int ST_EMPTY    = 6;
  localparam int ST_COUNT_LO = 0;
  localparam int ST_COUNT_W  = 5;

  typedef struct packed {
    logic [7:0]        addr;
    logic              rd;
    logic              wr;
    logic [BUS_DW-1:0] wdata;
  } bus_req_t;

  // Assemble the STATUS word from its fields; unused bits read as zero.
  function automatic logic [BUS_DW-1:0] status_word(
    input logic                  overflow,
    input logic                  collide,
    input logic                  full,
    input logic                  empty,
    input logic [ST_COUNT_W-1:0] count
  );
    logic [BUS_DW-1:0] w;
    w = '0;
    w[ST_OVERFLOW] = overflow;
    w[ST_COLLIDE]  = collide;
    w[ST_FULL]     = full;
    w[ST_EMPTY]    = empty;
    w[ST_COUNT_LO +: ST_COUNT_W] = count;
    return w;
  endfunction

endpackage

// File: rtl/bus_responder_sync_fifo.sv
// Synchronous FIFO with occupancy count; head reads as zero when empty.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage; contents need no reset since the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (!rst && do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/bus_responder.sv
// Memory-mapped slave: data RAM, cycle counter, output FIFO and STATUS flags.
module bus_responder
  import bus_responder_pkg::*;
#(
  parameter int RAM_WORDS  = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [7:0]        addr,
  input  logic              rd,
  input  logic              wr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int         AW      = $clog2(RAM_WORDS);
  localparam int         CW      = $clog2(FIFO_DEPTH + 1);
  localparam logic [7:0] RAM_LIM = 8'(RAM_WORDS);

  bus_req_t req;
  assign req = '{addr: addr, rd: rd, wr: wr, wdata: wdata};

  // Address decode
  logic ram_hit, cyc_hit, push_hit, stat_hit;
  logic [AW-1:0] ram_idx;
  assign ram_hit  = (req.addr < RAM_LIM);
  assign cyc_hit  = (req.addr == ADDR_CYCLES);
  assign push_hit = (req.addr == ADDR_FIFO_PUSH);
  assign stat_hit = (req.addr == ADDR_STATUS);
  assign ram_idx  = req.addr[AW-1:0];

  // Zero at configuration; reset leaves contents alone.
  logic [DATA_W-1:0] ram [RAM_WORDS] = '{default: '0};
  logic [DATA_W-1:0] cycles;
  logic              overflow, collide;

  // Output FIFO
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic              overflow_ev;

  assign fifo_push   = req.wr && push_hit;
  assign fifo_pop    = out_valid && out_ready;
  assign overflow_ev = fifo_push && fifo_full && !fifo_pop;
  assign out_valid   = !fifo_empty;

  sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (req.wdata),
    .rdata (out_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Read mux over pre-edge state
  logic [DATA_W-1:0] rd_mux;
  always_comb begin
    rd_mux = '0;
    if (ram_hit)       rd_mux = ram[ram_idx];
    else if (cyc_hit)  rd_mux = cycles;
    else if (stat_hit) rd_mux = status_word(overflow, collide, fifo_full, fifo_empty,
                                            ST_COUNT_W'(fifo_count));
  end

  // RAM write port; writes are suppressed during reset
  always_ff @(posedge CLK) begin
    if (!RST && req.wr && ram_hit) ram[ram_idx] <= req.wdata;
  end

  // Free-running cycle counter, loadable by a bus write
  always_ff @(posedge CLK) begin
    if (RST)                    cycles <= '0;
    else if (req.wr && cyc_hit) cycles <= req.wdata;
    else                        cycles <= cycles + DATA_W'(1);
  end

  // Sticky flags; a new event in the same cycle as a clear wins over the clear
  always_ff @(posedge CLK) begin
    if (RST) begin
      overflow <= 1'b0;
      collide  <= 1'b0;
    end else begin
      if (req.wr && stat_hit && req.wdata[0]) begin
        overflow <= 1'b0;
        collide  <= 1'b0;
      end
      if (overflow_ev)       overflow <= 1'b1;
      if (req.rd && req.wr)  collide  <= 1'b1;
    end
  end

  // Read data register; holds between reads, zero on an illegal rd+wr
  always_ff @(posedge CLK) begin
    if (RST)         rdata <= '0;
    else if (req.rd) rdata <= req.wr ? '0 : rd_mux;
  end

endmodule

// File: tb/tb_bus_responder.sv
// Directed plus randomized bench for bus_responder against a queue/array reference model.
module tb_bus_responder;

  localparam int DEPTH = 4;
  localparam int WORDS = 64;

  logic        CLK = 1'b0;
  logic        RST, rd, wr, out_ready;
  logic [7:0]  addr;
  logic [31:0] wdata, rdata, out_data;
  logic        out_valid;

  int checks = 0;
  int errors = 0;

  bus_responder #(.RAM_WORDS(WORDS), .FIFO_DEPTH(DEPTH), .DATA_W(32)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .addr      (addr),
    .rd        (rd),
    .wr        (wr),
    .wdata     (wdata),
    .rdata     (rdata),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 CLK = ~CLK;

  // Reference model state (post-edge view)
  logic [31:0] m_ram [WORDS];
  logic [31:0] m_q [$];
  logic [31:0] m_cyc, m_rdata;
  logic        m_ovf, m_col;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [7:0] a);
    logic [31:0] v;
    int n;
    v = 32'h0;
    n = m_q.size();
    if (a < 8'(WORDS))    v = m_ram[a[5:0]];
    else if (a == 8'h40)  v = m_cyc;
    else if (a == 8'h42) begin
      v[31]  = m_ovf;
      v[30]  = m_col;
      v[7]   = (n == DEPTH);
      v[6]   = (n == 0);
      v[4:0] = 5'(n);
    end
    return v;
  endfunction

  // One bus edge of the model, following the address map rules directly
  task automatic m_step(input logic r_rst, input logic r_rd, input logic r_wr,
                        input logic [7:0] a, input logic [31:0] d, input logic rdy);
    logic pop, push, was_full;
    if (r_rst) begin
      m_rdata = 0; m_cyc = 0; m_q.delete(); m_ovf = 0; m_col = 0;
      return;
    end
    if (r_rd) m_rdata = r_wr ? 32'h0 : m_read(a);
    pop      = (m_q.size() > 0) && rdy;
    push     = r_wr && (a == 8'h41);
    was_full = (m_q.size() == DEPTH);
    if (r_wr && a == 8'h42 && d[0]) begin m_ovf = 0; m_col = 0; end
    if (r_rd && r_wr) m_col = 1;
    if (push && was_full && !pop) m_ovf = 1;
    if (pop) void'(m_q.pop_front());
    if (push && m_q.size() < DEPTH) m_q.push_back(d);
    m_cyc = (r_wr && a == 8'h40) ? d : m_cyc + 32'd1;
    if (r_wr && a < 8'(WORDS)) m_ram[a[5:0]] = d;
  endtask

  // Drive one cycle from a negedge, then check outputs at the following negedge
  task automatic tick(input logic r_rst, input logic r_rd, input logic r_wr,
                      input logic [7:0] a, input logic [31:0] d, input logic rdy);
    RST = r_rst; rd = r_rd; wr = r_wr; addr = a; wdata = d; out_ready = rdy;
    m_step(r_rst, r_rd, r_wr, a, d, rdy);
    @(negedge CLK);
    chk("rdata", rdata, m_rdata);
    chk("out_valid", {31'b0, out_valid}, {31'b0, m_q.size() != 0});
    chk("out_data", out_data, (m_q.size() != 0) ? m_q[0] : 32'h0);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 8'h00, 32'h0, rdy);
  endtask

  task automatic rd_at(input logic [7:0] a, input logic rdy);
    tick(0, 1, 0, a, 32'h0, rdy);
  endtask

  task automatic wr_at(input logic [7:0] a, input logic [31:0] d, input logic rdy);
    tick(0, 0, 1, a, d, rdy);
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++) m_ram[i] = 32'h0;
    m_cyc = 0; m_rdata = 0; m_ovf = 0; m_col = 0;
    RST = 1; rd = 0; wr = 0; addr = 0; wdata = 0; out_ready = 0;

    // Reset state
    tick(1, 0, 0, 8'h00, 32'h0, 0);
    tick(1, 0, 0, 8'h00, 32'h0, 0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_valid", {31'b0, out_valid}, 32'h0);

    // RAM round trip and unwritten word
    wr_at(8'h05, 32'hDEADBEEF, 0);
    rd_at(8'h05, 0);
    chk("ram_rt", rdata, 32'hDEADBEEF);
    rd_at(8'h06, 0);
    chk("ram_unwritten", rdata, 32'h0);
    idle(2, 0);
    chk("rdata_hold", rdata, 32'h0);

    // Counter: 10 cycles after reset release, then wrap
    tick(1, 0, 0, 8'h00, 32'h0, 0);
    idle(10, 0);
    rd_at(8'h40, 0);
    chk("cycles_10", rdata, 32'd10);
    wr_at(8'h40, 32'hFFFFFFFE, 0);
    idle(2, 0);
    rd_at(8'h40, 0);
    chk("cycles_wrap", rdata, 32'h0);
    rd_at(8'h43, 0);
    chk("unmapped", rdata, 32'h0);
    rd_at(8'h41, 0);
    chk("push_reads_0", rdata, 32'h0);

    // FIFO fill without drain, overflow, flag clear
    for (int i = 1; i <= 4; i++) wr_at(8'h41, 32'(i), 0);
    rd_at(8'h42, 0);
    chk("status_full", rdata, 32'h0000_0084);
    wr_at(8'h41, 32'd5, 0);
    rd_at(8'h42, 0);
    chk("status_ovf", rdata, 32'h8000_0084);
    wr_at(8'h42, 32'h1, 0);
    rd_at(8'h42, 0);
    chk("status_clr", rdata, 32'h0000_0084);

    // Drain in order
    for (int i = 1; i <= 4; i++) begin
      chk("drain_head", out_data, 32'(i));
      idle(1, 1);
    end
    chk("drained_valid", {31'b0, out_valid}, 32'h0);
    rd_at(8'h42, 0);
    chk("status_empty", rdata, 32'h0000_0040);

    // Push while full with a simultaneous pop
    for (int i = 0; i < 4; i++) wr_at(8'h41, 32'h100 + 32'(i), 0);
    wr_at(8'h41, 32'h200, 1);
    rd_at(8'h42, 0);
    chk("full_push_pop", rdata, 32'h0000_0084);
    idle(6, 1);

    // Collision
    tick(0, 1, 1, 8'h10, 32'd7, 0);
    chk("collide_rdata", rdata, 32'h0);
    rd_at(8'h10, 0);
    chk("collide_ram", rdata, 32'd7);
    rd_at(8'h42, 0);
    chk("collide_flag", rdata, 32'h4000_0040);

    // Reset mid-stream
    for (int i = 0; i < 3; i++) wr_at(8'h41, 32'hA0 + 32'(i), 0);
    rd_at(8'h10, 0);
    tick(1, 1, 0, 8'h10, 32'h0, 1);
    chk("midrst_rdata", rdata, 32'h0);
    chk("midrst_valid", {31'b0, out_valid}, 32'h0);
    rd_at(8'h40, 0);
    chk("midrst_cycles", rdata, 32'h0);
    rd_at(8'h10, 0);
    chk("midrst_ram", rdata, 32'd7);
    rd_at(8'h05, 0);
    chk("midrst_ram2", rdata, 32'hDEADBEEF);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] a;
      logic r_rd, r_wr, r_rst, rdy;
      logic [31:0] d;
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 4)       a = 8'($urandom_range(0, 7));
      else if (sel < 8)  a = 8'h40 + 8'($urandom_range(0, 3));
      else if (sel < 9)  a = 8'($urandom_range(0, 63));
      else               a = 8'($urandom_range(0, 255));
      d     = $urandom();
      if (a == 8'h42 && $urandom_range(0, 3) != 0) d[0] = 1'b0;
      r_rd  = ($urandom_range(0, 2) == 0);
      r_wr  = ($urandom_range(0, 2) == 0);
      if (r_rd && r_wr && $urandom_range(0, 7) != 0) r_wr = 1'b0;
      r_rst = ($urandom_range(0, 199) == 0);
      rdy   = ($urandom_range(0, 2) == 0);
      tick(r_rst, r_rd, r_wr, a, d, rdy);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_responder.md
Name: bus_responder

Overview:
- Target end of the controller's data bus. Decodes the 8-bit address, read strobe, write strobe and 32-bit write data that the processor issues. Returns read data on its bus-input port in the following cycle.
- Provides a data RAM, a free-running cycle counter and an output FIFO drained by an external valid/ready consumer.
- Sits between the processor and the outside world; it is the only memory-mapped slave on the bus.

Parameters:
- RAM_WORDS, 64, number of 32-bit RAM words mapped at 0x00..RAM_WORDS-1 (power of two, max 64).
- FIFO_DEPTH, 4, output FIFO entries (power of two, 2..16).
- DATA_W, 32, bus data width (fixed at 32 for the current processor).

Ports:
- CLK  in  1  system clock, all state on rising edge.
- RST  in  1  synchronous active-high reset.
- addr  in  8  word address from controller.
- rd  in  1  read strobe, single-cycle.
- wr  in  1  write strobe, single-cycle.
- wdata  in  32  write data (accumulator value).
- rdata  out  32  read data, connected to controller bus input.
- out_data  out  32  FIFO head.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts head this cycle.

Behaviour:
- Interface: one clock, CLK; reset RST is synchronous, active-high.
- Reset values: rdata=0, counter=0, FIFO empty (out_valid=0, out_data=0), sticky flags=0. RST does not clear RAM; RAM is zero-initialised at configuration.
- Address map:
  - 0x00..RAM_WORDS-1: RAM, read/write.
  - 0x40 CYCLES: read/write.
  - 0x41 FIFO_PUSH: write pushes wdata; read returns 0.
  - 0x42 STATUS: read returns {overflow[31], collide[30], 22'b0, full[7], empty[6], 1'b0, count[4:0]}. A write with wdata[0]=1 clears both sticky flags.
  - All other addresses: reads return 0, writes are ignored.
- Read latency:
  - rd=1 at edge t loads rdata with the addressed value at t; rdata is valid throughout cycle t+1, when the controller samples it.
  - rdata holds its value until the next read.
  - Cycles with rd=0 do not change rdata.
- Write: wr=1 at edge t commits at t. A read at t+1 of the same address returns the new value. There is no same-edge bypass, because the bus never issues rd and wr together.
- rd=wr=1 (illegal):
  - The write is performed.
  - rdata loads 0.
  - collide sets (sticky).
- CYCLES:
  - Increments by 1 every cycle and wraps 0xFFFFFFFF -> 0.
  - A write of V at edge t makes the counter V at t, V+1 at t+1.
  - A read returns the pre-edge value.
- FIFO:
  - out_valid = !empty; out_data = head entry (0 when empty).
  - Pop when out_valid & out_ready.
  - A push into an empty FIFO makes out_valid=1 from the next cycle; there is no fall-through.
  - Push while full with no pop: data is dropped, overflow sets (sticky), contents are unchanged.
  - Push while full with a simultaneous pop: both take effect, count stays FIFO_DEPTH.
  - Push and pop while non-empty and not full: count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - count ranges 0..FIFO_DEPTH.
- Arithmetic: all counters are unsigned modulo 2^width, with no saturation.
- RST mid-operation: it overrides any same-cycle rd/wr/pop.
  - FIFO empties and pending data is discarded.
  - rdata=0; a read issued in the reset cycle returns 0.

Decomposition:
- Shared package holds: address constants ADDR_CYCLES=8'h40, ADDR_FIFO_PUSH=8'h41, ADDR_STATUS=8'h42; STATUS bit positions; bus request struct {addr, rd, wr, wdata}.
- One sub-module, sync_fifo (parameters DEPTH, WIDTH): push/pop/full/empty/count, synchronous reset. Used for the output FIFO; the top level holds decode, RAM, counter, flags and the rdata register.

Test Plan:
- RAM round trip: write 0xDEADBEEF to 0x05 at t, rd 0x05 at t+1 -> rdata=0xDEADBEEF during t+2. A read of 0x06 (never written) -> 0.
- Counter: 10 cycles after RST release, read 0x40 -> 10. Write 0xFFFFFFFE, read 2 cycles later -> 0x00000000 (wrap). Read 0x43 -> 0.
- FIFO fill, no drain (out_ready=0): push 1,2,3,4 -> STATUS count=4, full=1. Push 5 -> overflow=1, contents still 1..4. Write STATUS with wdata=1 -> overflow=0.
- Drain: out_ready=1 after the fill -> out_data 1,2,3,4 on consecutive cycles, then out_valid=0, empty=1. A push at full with a simultaneous pop -> accepted, no overflow.
- Collision: rd=wr=1 at 0x10 with wdata=7 -> RAM[0x10]=7, rdata=0, collide=1.
- Reset mid-stream: FIFO holds 3 entries, assert RST one cycle with rd=1 -> out_valid=0, rdata=0, counter=0, RAM contents preserved.
